// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared definitions for the serial pattern scanner: controller state encoding and reset defaults.
package pattern_scan_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } scan_state_e;

  localparam logic [5:0] DEFAULT_PATTERN = 6'b111010;
  localparam logic       DEFAULT_OVERLAP = 1'b1;

endpackage

// File: rtl/pattern_det_core.sv
// Bit-serial pattern detector: history/fill tracking, match registered 1 cycle after the shifted bit.
// No backpressure; consumes one bit whenever bit_valid is high, clear has priority.
module pattern_det_core #(
  parameter int PAT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic             clear,
  output logic             hit,
  output logic             match
);

  localparam int                FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic              match_q, match_d;

  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], bit_in};
    fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    hit        = bit_valid && (hist_shift == pattern) && (fill_inc == FILL_FULL);

    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_valid) begin
      hist_d  = hist_shift;
      // Non-overlapping mode restarts the window after every hit.
      fill_d  = (hit && !overlap) ? '0 : fill_inc;
      match_d = hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Word-to-bit serializer feeding pattern_det_core; one bit per cycle, match 1 cycle after its bit.
// in_ready drops while a word is shifting and reopens on its last bit for gap-free back-to-back words.
module pattern_scan_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              match,
  output logic [CNT_W-1:0]  match_count
);

  import pattern_scan_ctrl_pkg::*;

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  scan_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic              overlap_q, overlap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic accept;
  logic cfg_eff;
  logic shifting;
  logic det_hit;
  logic det_match;

  always_comb begin
    shifting = (state_q == ST_SHIFT);
    in_ready = !shifting || (idx_q == '0);
    accept   = in_valid && in_ready;
    // A handshake in IDLE takes precedence; configuration is never queued.
    cfg_eff  = cfg_we && !shifting && !accept;

    state_d   = state_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    pattern_d = pattern_q;
    overlap_d = overlap_q;
    cnt_d     = cnt_q;

    if (accept) begin
      state_d = ST_SHIFT;
      idx_d   = IDX_W'(DATA_W - 1);
      shreg_d = in_data;
    end else if (shifting) begin
      if (idx_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        idx_d = idx_q - IDX_W'(1);
      end
    end

    if (cfg_eff) begin
      pattern_d = cfg_pattern;
      overlap_d = cfg_overlap;
      cnt_d     = '0;
    end else if (det_hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      shreg_q   <= '0;
      pattern_q <= PAT_W'(DEFAULT_PATTERN);
      overlap_q <= DEFAULT_OVERLAP;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      cnt_q     <= cnt_d;
    end
  end

  pattern_det_core #(
    .PAT_W (PAT_W)
  ) u_det (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (shifting),
    .bit_in    (shreg_q[idx_q]),
    .pattern   (pattern_q),
    .overlap   (overlap_q),
    .clear     (cfg_eff),
    .hit       (det_hit),
    .match     (det_match)
  );

  assign busy        = shifting;
  assign match       = det_match;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl with a queue-based bit-stream reference model.
module tb_pattern_scan_ctrl;

  localparam int DATA_W  = 8;
  localparam int PAT_W   = 6;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic              cfg_we;
  logic [PAT_W-1:0]  cfg_pattern;
  logic              cfg_overlap;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              busy;
  logic              match;
  logic [CNT_W-1:0]  match_count;

  pattern_scan_ctrl #(
    .DATA_W (DATA_W),
    .PAT_W  (PAT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .busy        (busy),
    .match       (match),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending bits to serialize, and the recent bit stream since the last clear.
  bit             pend[$];
  bit             hist[$];
  int             fill_m  = 0;
  logic [PAT_W-1:0] pat_m = 6'b111010;
  bit             ovl_m   = 1'b1;
  int             cnt_m   = 0;
  bit             match_m = 1'b0;
  int             edge_n  = 0;
  bit             m_acc;
  bit             m_bit;
  int             m_val;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend.delete();
      hist.delete();
      fill_m  = 0;
      pat_m   = 6'b111010;
      ovl_m   = 1'b1;
      cnt_m   = 0;
      match_m = 1'b0;
    end else begin
      edge_n++;
      m_acc   = in_valid && (pend.size() <= 1);
      match_m = 1'b0;
      if (pend.size() > 0) begin
        m_bit = pend.pop_front();
        hist.push_back(m_bit);
        if (hist.size() > PAT_W) hist.delete(0);
        if (fill_m < PAT_W) fill_m++;
        m_val = 0;
        foreach (hist[i]) m_val = (m_val << 1) | int'(hist[i]);
        if (fill_m == PAT_W && m_val == int'(pat_m)) begin
          match_m = 1'b1;
          if (cnt_m < CNT_MAX) cnt_m++;
          if (!ovl_m) fill_m = 0;
        end
      end else if (cfg_we && !m_acc) begin
        pat_m  = cfg_pattern;
        ovl_m  = cfg_overlap;
        hist.delete();
        fill_m = 0;
        cnt_m  = 0;
      end
      if (m_acc) begin
        for (int i = DATA_W - 1; i >= 0; i--) pend.push_back(in_data[i]);
      end
    end
  end

  int match_edges[$];

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(pend.size() <= 1));
      chk("busy", 32'(busy), 32'(pend.size() > 0));
      chk("match", 32'(match), 32'(match_m));
      chk("match_count", 32'(match_count), 32'(cnt_m));
      if (match) match_edges.push_back(edge_n);
    end
  end

  task automatic send(input logic [DATA_W-1:0] d, output int base);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    base     = edge_n;
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
  endtask

  task automatic cfg(input logic [PAT_W-1:0] p, input logic ov);
    @(negedge clk);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_overlap = ov;
    @(negedge clk);
    cfg_we      = 1'b0;
  endtask

  task automatic chk_matches(input string name, input int base, input int n,
                             input int off0, input int off1);
    chk({name, "_nmatch"}, 32'(match_edges.size()), 32'(n));
    if (n > 0) chk({name, "_edge0"}, 32'(match_edges.size() > 0 ? match_edges[0] - base : -1), 32'(off0));
    if (n > 1) chk({name, "_edge1"}, 32'(match_edges.size() > 1 ? match_edges[1] - base : -1), 32'(off1));
  endtask

  int base;

  initial begin
    clk         = 1'b0;
    rst         = 1'b1;
    cfg_we      = 1'b0;
    cfg_pattern = '0;
    cfg_overlap = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;

    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Default pattern 111010 against 8'hE8: one hit after the sixth bit.
    match_edges.delete();
    send(8'hE8, base);
    repeat (10) @(negedge clk);
    chk_matches("t1", base, 1, 6, 0);
    chk("t1_count", 32'(match_count), 32'd1);
    chk("t1_ready", 32'(in_ready), 32'd1);

    // 101010 with overlap over 8'hAA: hits after bits 6 and 8.
    cfg(6'b101010, 1'b1);
    match_edges.delete();
    send(8'hAA, base);
    repeat (10) @(negedge clk);
    chk_matches("t2", base, 2, 6, 8);
    chk("t2_count", 32'(match_count), 32'd2);

    // Same without overlap: the window restarts, so only one hit.
    cfg(6'b101010, 1'b0);
    match_edges.delete();
    send(8'hAA, base);
    repeat (10) @(negedge clk);
    chk_matches("t3", base, 1, 6, 0);
    chk("t3_count", 32'(match_count), 32'd1);

    // Back-to-back 03, A0 with in_valid held: the pattern spans the word boundary.
    cfg(6'b111010, 1'b1);
    match_edges.delete();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h03;
    @(negedge clk);
    base    = edge_n;
    in_data = 8'hA0;
    repeat (7) @(negedge clk);
    chk("t4_ready_last_bit", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("t4_busy_after_e8", 32'(busy), 32'd1);
    chk("t4_ready_after_e8", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk_matches("t4", base, 1, 12, 0);
    chk("t4_count", 32'(match_count), 32'd1);

    // All-zero pattern over 33 zero bytes: 259 hits saturate the counter.
    cfg(6'b000000, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h00;
    repeat (257) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("t5_count_sat", 32'(match_count), 32'd255);

    // Asynchronous reset in the middle of a word restores defaults at once.
    cfg(6'b101010, 1'b0);
    send(8'hAA, base);
    repeat (10) @(negedge clk);
    chk("t6_pre_count", 32'(match_count), 32'd1);
    send(8'hE8, base);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(in_ready), 32'd1);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_count", 32'(match_count), 32'd0);
    chk("t6_rst_match", 32'(match), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hE8;
    match_edges.delete();
    @(negedge clk);
    base     = edge_n;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk_matches("t6", base, 1, 6, 0);
    chk("t6_count", 32'(match_count), 32'd1);

    // Configuration attempted mid-word is dropped.
    match_edges.delete();
    send(8'hE8, base);
    repeat (2) @(negedge clk);
    cfg_we      = 1'b1;
    cfg_pattern = 6'b000000;
    cfg_overlap = 1'b0;
    @(negedge clk);
    cfg_we = 1'b0;
    repeat (10) @(negedge clk);
    chk_matches("t7", base, 1, 6, 0);
    chk("t7_count", 32'(match_count), 32'd2);

    // Configuration colliding with a handshake in IDLE loses to the handshake.
    match_edges.delete();
    @(negedge clk);
    in_valid    = 1'b1;
    in_data     = 8'hE8;
    cfg_we      = 1'b1;
    cfg_pattern = 6'b101010;
    cfg_overlap = 1'b0;
    @(negedge clk);
    base     = edge_n;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    repeat (10) @(negedge clk);
    chk_matches("t8", base, 1, 6, 0);
    chk("t8_count", 32'(match_count), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 The parameter list SHALL be: DATA_W, default 8, input word width; PAT_W, default 6, pattern length; CNT_W, default 8, match counter width.
REQ-002 The module SHALL have port `clk`: input, 1 bit, single clock, rising edge.
REQ-003 The module SHALL have port `rst`: input, 1 bit, asynchronous, active-high reset.
REQ-004 The module SHALL have port `cfg_we`: input, 1 bit, configuration write strobe.
REQ-005 The module SHALL have port `cfg_pattern`: input, PAT_W bits, target pattern; the MSB is the oldest bit.
REQ-006 The module SHALL have port `cfg_overlap`: input, 1 bit; 1 = overlapping matches allowed.
REQ-007 The module SHALL have port `in_valid`: input, 1 bit, input word valid.
REQ-008 The module SHALL have port `in_data`: input, DATA_W bits, word to scan; serialized MSB first.
REQ-009 The module SHALL have port `in_ready`: output, 1 bit, controller can accept a word.
REQ-010 The module SHALL have port `busy`: output, 1 bit, serialization in progress.
REQ-011 The module SHALL have port `match`: output, 1 bit, one-cycle pulse per detected pattern.
REQ-012 The module SHALL have port `match_count`: output, CNT_W bits, saturating match count.

Function
REQ-013 The controller FSM SHALL have two states: IDLE and SHIFT.
REQ-014 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL be 1 in IDLE, and also in SHIFT when the current bit index is 0 (last bit); it SHALL be 0 otherwise.
REQ-016 On acceptance, the word SHALL be captured in a shift register, bit index set to DATA_W-1, and the state SHALL move to SHIFT.
REQ-017 In SHIFT, each rising edge SHALL shift the bit at the current index into a PAT_W-bit history register (LSB = newest) and decrement the index.
REQ-018 When index 0 is shifted with no simultaneous acceptance, the next state SHALL be IDLE.
REQ-019 When index 0 is shifted with a simultaneous acceptance, the controller SHALL reload and remain in SHIFT; sustained throughput is one word per DATA_W cycles, with no bubble.
REQ-020 The detector SHALL keep a fill counter, 0..PAT_W and saturating, of valid history bits.
REQ-021 The fill counter SHALL increment per shifted bit.
REQ-022 History and fill SHALL persist across word boundaries, so the stream is continuous.
REQ-023 match SHALL be registered high for exactly one cycle after the edge that shifts in a bit, when the updated history equals cfg_pattern and the updated fill equals PAT_W.
REQ-024 On a match with overlap=0, fill SHALL clear to 0 on the same edge.
REQ-025 On a match with overlap=1, fill SHALL be retained.
REQ-026 match_count SHALL increment on each match and saturate at 2^CNT_W-1; it SHALL never wrap.
REQ-027 busy SHALL be 1 exactly when the state is SHIFT.
REQ-028 cfg_we SHALL take effect only in IDLE with no simultaneous acceptance.
REQ-029 An effective cfg_we SHALL load the pattern register and the overlap register, and clear history, fill and match_count.
REQ-030 cfg_we while busy SHALL be ignored, with no queuing.
REQ-031 If cfg_we and a handshake coincide in IDLE, the handshake SHALL win and cfg_we SHALL be dropped.
REQ-032 in_data SHALL be sampled only on the acceptance edge; later changes SHALL have no effect.
REQ-033 in_valid=1 while in_ready=0 SHALL have no effect.

Reset
REQ-034 While rst=1 (asynchronous), the block SHALL hold: state IDLE, in_ready=1, busy=0, match=0, match_count=0, history=0, fill=0, bit index=0.
REQ-035 While rst=1, the block SHALL hold pattern=6'b111010 and overlap=1.
REQ-036 Reset asserted mid-SHIFT SHALL discard the partial word immediately.
REQ-037 After reset release, the first acceptance SHALL be possible on the first rising edge.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding (IDLE=1'b0, SHIFT=1'b1) and the default pattern constant 6'b111010.
REQ-039 A single sub-module, pattern_det_core, SHALL contain the history register, fill counter, comparator and match register, with inputs bit_valid, bit_in, pattern, overlap and clear.
REQ-040 Serialization, handshake, configuration and the counter SHALL reside in pattern_scan_ctrl.

Verification
REQ-041 Reset defaults, byte 8'hE8 accepted at edge E0 -> match high in the cycle after E6 only; match_count=1; in_ready=1 after E8.
REQ-042 Config pattern 6'b101010 with overlap=1, byte 8'hAA -> matches after E6 and E8; match_count=2.
REQ-043 Same pattern with overlap=0, byte 8'hAA -> single match after E6; match_count=1.
REQ-044 Back-to-back: in_valid held high, bytes 8'h03 then 8'hA0, default pattern -> second byte accepted at E8 with no idle cycle; match after E12 (bit stream 111010 spans the boundary).
REQ-045 Pattern 6'b000000 with overlap=1, 33 bytes of 8'h00 -> match_count saturates at 255; no wrap.
REQ-046 Async rst pulse mid-SHIFT (after E3) -> immediately IDLE, in_ready=1, match_count=0, pattern restored to 111010.
REQ-047 cfg_we during SHIFT -> pattern unchanged.
